// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle for fft_bitrev_reorder: bit-reversed input side, natural-order
// output side, error pulses and the test-mode reader hold.
interface fft_bitrev_reorder_if #(
  parameter int unsigned N     = 64,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned LOG_N = $clog2(N);

  logic             di_en;
  logic [WIDTH-1:0] di_re;
  logic [WIDTH-1:0] di_im;
  // Test mode: keeps the reader from starting a new frame.
  logic             rd_hold;

  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic [LOG_N-1:0] do_idx;
  logic             do_last;
  logic             err_short;
  logic             err_ovf;

  modport master (
    output di_en, di_re, di_im, rd_hold,
    input  do_en, do_re, do_im, do_idx, do_last, err_short, err_ovf
  );

  modport slave (
    input  di_en, di_re, di_im, rd_hold,
    output do_en, do_re, do_im, do_idx, do_last, err_short, err_ovf
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order using a
// ping-pong pair of N-entry banks; sustains one sample per cycle.
module fft_bitrev_reorder #(
  parameter int unsigned N     = 64,
  parameter int unsigned WIDTH = 16
) (
  input logic                 clock,
  input logic                 reset,
  fft_bitrev_reorder_if.slave bus
);
  localparam int unsigned LOG_N = $clog2(N);
  localparam logic [LOG_N-1:0] LastCnt = LOG_N'(N - 1);

  typedef enum logic [1:0] {WIdle, WFill, WDrop} w_state_e;
  typedef enum logic       {RIdle, RRead}        r_state_e;

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < int'(LOG_N); i++) begin
      r[i] = v[int'(LOG_N) - 1 - i];
    end
    return r;
  endfunction

  // Writer state
  w_state_e         w_state_q;
  logic [LOG_N-1:0] wcnt_q;
  logic             wbank_q;
  logic             err_short_q;
  logic             err_ovf_q;

  // Reader state
  r_state_e         r_state_q;
  logic [LOG_N-1:0] rcnt_q;
  logic             rbank_q;

  logic [1:0]       full_q, full_d;

  logic [2*WIDTH-1:0] mem [2*N];
  logic [2*WIDTH-1:0] rdata_q;
  logic               rvld_q;
  logic [LOG_N-1:0]   ridx_q;

  logic             do_en_q;
  logic [WIDTH-1:0] do_re_q;
  logic [WIDTH-1:0] do_im_q;
  logic [LOG_N-1:0] do_idx_q;
  logic             do_last_q;

  logic             wr_we;
  logic             wr_done;
  logic [LOG_N:0]   wr_addr;
  logic             rd_fire;
  logic             rd_done;
  logic [LOG_N-1:0] rd_idx;
  logic [LOG_N:0]   rd_addr;

  always_comb begin
    wr_we   = bus.di_en && ((w_state_q == WFill) ||
                            ((w_state_q == WIdle) && !full_q[wbank_q]));
    wr_done = bus.di_en && (w_state_q == WFill) && (wcnt_q == LastCnt);
    // Sample at stream position p belongs to bin bitrev(p).
    wr_addr = {wbank_q, bitrev(wcnt_q)};
  end

  // Address 0 is issued straight from RIdle so a newly full bank costs no gap.
  always_comb begin
    rd_fire = (r_state_q == RRead) || (full_q[rbank_q] && !bus.rd_hold);
    rd_idx  = (r_state_q == RRead) ? rcnt_q : '0;
    rd_done = (r_state_q == RRead) && (rcnt_q == LastCnt);
    rd_addr = {rbank_q, rd_idx};
  end

  always_comb begin
    full_d = full_q;
    for (int b = 0; b < 2; b++) begin
      if (wr_done && (wbank_q == 1'(b))) full_d[b] = 1'b1;
      if (rd_done && (rbank_q == 1'(b))) full_d[b] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= '0;
    end else begin
      full_q <= full_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_q   <= WIdle;
      wcnt_q      <= '0;
      wbank_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      unique case (w_state_q)
        WIdle: begin
          if (bus.di_en) begin
            wcnt_q <= LOG_N'(1);
            if (full_q[wbank_q]) begin
              w_state_q <= WDrop;
              err_ovf_q <= 1'b1;
            end else begin
              w_state_q <= WFill;
            end
          end
        end
        WFill: begin
          if (!bus.di_en) begin
            w_state_q   <= WIdle;
            wcnt_q      <= '0;
            err_short_q <= 1'b1;
          end else if (wcnt_q == LastCnt) begin
            w_state_q <= WIdle;
            wcnt_q    <= '0;
            wbank_q   <= ~wbank_q;
          end else begin
            wcnt_q <= wcnt_q + LOG_N'(1);
          end
        end
        WDrop: begin
          // Counting through a dropped frame lets a back-to-back successor start cleanly.
          if (!bus.di_en || (wcnt_q == LastCnt)) begin
            w_state_q <= WIdle;
            wcnt_q    <= '0;
          end else begin
            wcnt_q <= wcnt_q + LOG_N'(1);
          end
        end
        default: begin
          w_state_q <= WIdle;
          wcnt_q    <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_q <= RIdle;
      rcnt_q    <= '0;
      rbank_q   <= 1'b0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (rd_fire) begin
            r_state_q <= RRead;
            rcnt_q    <= LOG_N'(1);
          end
        end
        RRead: begin
          if (rcnt_q == LastCnt) begin
            r_state_q <= RIdle;
            rcnt_q    <= '0;
            rbank_q   <= ~rbank_q;
          end else begin
            rcnt_q <= rcnt_q + LOG_N'(1);
          end
        end
        default: begin
          r_state_q <= RIdle;
          rcnt_q    <= '0;
        end
      endcase
    end
  end

  // Bank storage: one write port, one synchronous read port, no reset.
  always_ff @(posedge clock) begin
    if (wr_we) begin
      mem[wr_addr] <= {bus.di_re, bus.di_im};
    end
    rdata_q <= mem[rd_addr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvld_q    <= 1'b0;
      ridx_q    <= '0;
      do_en_q   <= 1'b0;
      do_re_q   <= '0;
      do_im_q   <= '0;
      do_idx_q  <= '0;
      do_last_q <= 1'b0;
    end else begin
      rvld_q    <= rd_fire;
      ridx_q    <= rd_idx;
      do_en_q   <= rvld_q;
      do_re_q   <= rvld_q ? rdata_q[2*WIDTH-1:WIDTH] : '0;
      do_im_q   <= rvld_q ? rdata_q[WIDTH-1:0] : '0;
      do_idx_q  <= rvld_q ? ridx_q : '0;
      do_last_q <= rvld_q && (ridx_q == LastCnt);
    end
  end

  assign bus.do_en     = do_en_q;
  assign bus.do_re     = do_re_q;
  assign bus.do_im     = do_im_q;
  assign bus.do_idx    = do_idx_q;
  assign bus.do_last   = do_last_q;
  assign bus.err_short = err_short_q;
  assign bus.err_ovf   = err_ovf_q;

  // The writer only fills an empty bank and the reader only drains a full one.
  a_no_full_collision: assert property (@(posedge clock) disable iff (reset)
    !(wr_done && rd_done && (wbank_q == rbank_q)));
  a_no_rw_same_bank: assert property (@(posedge clock) disable iff (reset)
    !(wr_we && rd_fire && (wr_addr[LOG_N] == rd_addr[LOG_N])));
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomized scoreboard bench for fft_bitrev_reorder: a monitor pops expected
// natural-order samples whenever do_en is high.
module tb_fft_bitrev_reorder;
  localparam int N     = 64;
  localparam int WIDTH = 16;
  localparam int LOG_N = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fft_bitrev_reorder_if #(.N(N), .WIDTH(WIDTH)) bus ();
  fft_bitrev_reorder #(.N(N), .WIDTH(WIDTH)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    int               idx;
    bit               last;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_in_cyc, first_out_cyc;
  int run_len, last_run, gap_run, max_gap;
  int short_cnt, ovf_cnt, out_frames;
  bit prev_en, had_last;
  logic [WIDTH-1:0] got_re [N];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Bit reversal by repeated halving: the LSB of the position becomes the MSB.
  function automatic int rev_bits(int v);
    int r = 0;
    for (int i = 0; i < LOG_N; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (bus.err_short) short_cnt++;
      if (bus.err_ovf) ovf_cnt++;
      if (bus.do_en) begin
        run_len++;
        if (bus.do_idx == 0) begin
          first_out_cyc = cyc;
          if (had_last && gap_run > max_gap) max_gap = gap_run;
        end
        got_re[bus.do_idx] = bus.do_re;
        if (sb.size() == 0) begin
          check("unexpected_output", {bus.do_en, bus.do_idx}, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sample", {bus.do_re, bus.do_im, 8'(bus.do_idx), 7'd0, bus.do_last},
                {e.re, e.im, 8'(e.idx), 7'd0, e.last});
        end
        if (bus.do_last) begin
          out_frames++;
          had_last = 1'b1;
          gap_run  = 0;
        end
      end else begin
        gap_run++;
        if (prev_en) begin
          last_run = run_len;
          run_len  = 0;
        end
      end
      prev_en = bus.do_en;
    end
  end

  task automatic send_frame(input int len, input bit keep, input bit ramp);
    logic [WIDTH-1:0] re [N];
    logic [WIDTH-1:0] im [N];
    exp_t e;
    for (int p = 0; p < len; p++) begin
      @(negedge clock);
      re[p] = ramp ? WIDTH'(p) : WIDTH'($urandom);
      im[p] = ramp ? WIDTH'(-p) : WIDTH'($urandom);
      bus.di_en = 1'b1;
      bus.di_re = re[p];
      bus.di_im = im[p];
      if (p == len - 1) last_in_cyc = cyc + 1;
    end
    if (keep && len == N) begin
      for (int k = 0; k < N; k++) begin
        e.re   = re[rev_bits(k)];
        e.im   = im[rev_bits(k)];
        e.idx  = k;
        e.last = (k == N - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus.di_en = 1'b0;
      bus.di_re = '0;
      bus.di_im = '0;
    end
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) check(name, sb.size(), 0);
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int ovf0, short0, frames0;
    bit found;
    bus.di_en   = 1'b0;
    bus.di_re   = '0;
    bus.di_im   = '0;
    bus.rd_hold = 1'b0;
    #1 reset = 1'b1;
    #1 check("reset_outputs", {bus.do_en, bus.do_last, bus.err_short, bus.err_ovf,
                               bus.do_idx, bus.do_re, bus.do_im}, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Ramp frame: bin k carries position bitrev(k).
    send_frame(N, 1'b1, 1'b1);
    idle(2);
    wait_drain("drain_ramp");
    check("bin1_re", got_re[1], 32);
    check("bin3_re", got_re[3], 48);
    check("bin63_re", got_re[63], 63);
    check("latency", first_out_cyc - last_in_cyc, 2);
    check("do_en_run", last_run, N);

    // Four back-to-back random frames.
    had_last = 1'b0;
    max_gap  = 0;
    ovf0     = ovf_cnt;
    frames0  = out_frames;
    for (int f = 0; f < 4; f++) send_frame(N, 1'b1, 1'b0);
    idle(2);
    wait_drain("drain_b2b");
    check("b2b_gap_le1", (max_gap <= 1), 1);
    check("b2b_no_ovf", ovf_cnt - ovf0, 0);
    check("b2b_frames", out_frames - frames0, 4);

    // Short frame followed by a full one.
    short0  = short_cnt;
    frames0 = out_frames;
    send_frame(20, 1'b0, 1'b0);
    idle(3);
    check("short_pulse", short_cnt - short0, 1);
    send_frame(N, 1'b1, 1'b0);
    idle(2);
    wait_drain("drain_short");
    check("short_frames", out_frames - frames0, 1);
    check("short_once", short_cnt - short0, 1);

    // Asynchronous reset in the middle of a readout.
    send_frame(N, 1'b1, 1'b0);
    idle(1);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clock);
      #2;
      if (bus.do_en && bus.do_idx == 6'd30) found = 1'b1;
    end
    check("reached_idx30", found, 1);
    reset = 1'b1;
    #1 check("midreset_outputs", {bus.do_en, bus.do_last, bus.err_short, bus.err_ovf,
                                  bus.do_idx, bus.do_re, bus.do_im}, 0);
    sb.delete();
    run_len = 0;
    prev_en = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    frames0 = out_frames;
    send_frame(N, 1'b1, 1'b0);
    idle(2);
    wait_drain("drain_after_reset");
    check("post_reset_frames", out_frames - frames0, 1);

    // Hold the reader: two frames fill both banks, the third is dropped.
    bus.rd_hold = 1'b1;
    ovf0    = ovf_cnt;
    frames0 = out_frames;
    send_frame(N, 1'b1, 1'b0);
    send_frame(N, 1'b1, 1'b0);
    send_frame(N, 1'b0, 1'b0);
    idle(5);
    check("ovf_pulse", ovf_cnt - ovf0, 1);
    check("held_no_output", out_frames - frames0, 0);
    @(negedge clock);
    bus.rd_hold = 1'b0;
    wait_drain("drain_ovf");
    check("ovf_frames", out_frames - frames0, 2);
    check("ovf_once", ovf_cnt - ovf0, 1);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
